quiz_rank_detector: RTL and testbench
=====================================

// Module: quiz_rank_detector
// PURPOSE
//  N-channel quiz-button arbiter; successor to the 5-button ranker. Conditions each button, ranks
//  rising-edge presses per round, 1-based. Same-cycle presses tie; competition ranking (1,1,3).
//  Flags presses before arming as fouls. Sits between board button pins and score/display logic.
// PARAMETERS
//  N_BTN        8   number of button channels (2..16)
//  RANK_W       4   rank field width; must hold N_BTN (>= clog2(N_BTN+1))
//  SYNC_STAGES  2   synchroniser flops before the edge-detect flop (>= 2)
//  DB_CYCLES    16  stable cycles required by debounce (used only with QRD_DEBOUNCE_EN)
// PORTS
//  m_clock     in   1             system clock
//  p_reset     in   1             asynchronous active-low reset
//  clear       in   1             sync round clear -> IDLE, all ranks/fouls/counts zeroed
//  arm         in   1             1-cycle pulse: IDLE -> ARMED (ignored in other states)
//  BT          in   N_BTN         raw button levels, async, active-high
//  RANK_OUT    out  N_BTN*RANK_W  rank of channel i at [i*RANK_W +: RANK_W]; 0 = not ranked
//  foul        out  N_BTN         channel pressed while IDLE this round
//  first_id    out  RANK_W        lowest-index channel holding rank 1
//  first_valid out  1             some channel holds rank 1
//  press_cnt   out  RANK_W        number of channels ranked so far
//  all_done    out  1             high in DONE
// BEHAVIOUR
//  - Reset: every output 0; state IDLE; synchroniser/edge/debounce flops 0.
//  - Conditioning per channel: SYNC_STAGES flops, then prev flop; press = sync & ~prev.
//    A held button gives one press only. Press reaches RANK_OUT SYNC_STAGES+1 clocks
//    after the first m_clock edge that samples BT high.
//  - FSM IDLE -> ARMED on arm. ARMED -> DONE when every non-foul channel is ranked.
//    DONE holds until clear. clear wins over arm and press in the same cycle. Any state -> IDLE on clear.
//  - IDLE: press sets foul[i]; no ranking. A fouled channel is never ranked this round.
//    If all channels foul, arm goes straight to DONE on the next cycle.
//  - ARMED: let P = presses this cycle on unranked, non-foul channels. Each gets rank press_cnt+1.
//    press_cnt then increases by popcount(P), so ties skip ranks.
//    A rank is written once; later presses on that channel are ignored.
//  - first_id / first_valid are registered and update the cycle the rank-1 set is written.
//    Tie for first: lowest index wins.
//  - DONE: presses ignored; outputs frozen.
//  - Arithmetic: press_cnt <= N_BTN always; no wrap. popcount width is RANK_W.
//  - Reset mid-round: all state lost, back to IDLE, no partial round kept.
// CONFIGURATION
//  QRD_DEBOUNCE_EN defined:
//    the synchronised level is accepted only after DB_CYCLES consecutive equal samples.
//    Counter per channel; the edge detector follows the debounced level.
//    Latency becomes SYNC_STAGES+DB_CYCLES+1. Glitches shorter than DB_CYCLES produce no press.
//  QRD_DEBOUNCE_EN undefined: no counter; edge taken directly from the synchroniser; DB_CYCLES unused.
// STRUCTURE
//  - qrd_pkg: state enum {QRD_IDLE, QRD_ARMED, QRD_DONE}; default N_BTN/RANK_W constants;
//    popcount function.
//  - qrd_btn_cond: one sub-module per channel, generate loop.
//    Holds the synchroniser, optional debounce and edge detect. Output is a 1-cycle press pulse.
//  - Top: FSM, press_cnt, rank register array, foul bits, first-winner logic.
// TESTING
//  1. Reset, arm, BT[3] rises -> RANK_OUT[3]=1 after 3 clocks; first_id=3; press_cnt=1.
//  2. Armed, BT[1] and BT[5] rise in the same cycle, then BT[0] -> ranks 1,1,3; first_id=1; press_cnt=3.
//  3. BT[2] pressed in IDLE, then arm -> foul[2]=1; rank[2] stays 0 through a later press;
//     all_done once the other 7 are ranked.
//  4. BT[4] held high then pulsed 5 times while ARMED -> rank[4] written once, press_cnt +1 only.
//  5. clear and arm in the same cycle mid-round -> IDLE, all outputs 0.
//     p_reset low mid-round -> same, asynchronously.
//  6. QRD_DEBOUNCE_EN: 10-cycle glitch on BT[0] -> no rank.
//     20-cycle high -> rank 1 at SYNC_STAGES+17 clocks.

Source files
------------

// File: rtl/qrd_pkg.sv
// Shared types, default sizes and the popcount helper for the quiz rank detector.
package qrd_pkg;

    typedef enum logic [1:0] {
        QRD_IDLE  = 2'd0,
        QRD_ARMED = 2'd1,
        QRD_DONE  = 2'd2
    } qrd_state_e;

    localparam int unsigned QRD_N_BTN   = 8;
    localparam int unsigned QRD_RANK_W  = 4;
    localparam int unsigned QRD_MAX_BTN = 16;
    localparam int unsigned QRD_POP_W   = 5;

    function automatic logic [QRD_POP_W-1:0] qrd_popcount(input logic [QRD_MAX_BTN-1:0] v);
        logic [QRD_POP_W-1:0] c;
        c = '0;
        for (int i = 0; i < QRD_MAX_BTN; i++) begin
            c = c + QRD_POP_W'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/qrd_btn_cond.sv
// Per-channel button conditioning: synchroniser, optional debounce, rising-edge press pulse.
// Debounce is built only when QRD_DEBOUNCE_EN is defined.
module qrd_btn_cond
    import qrd_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DB_CYCLES   = 16
) (
    input  logic m_clock,
    input  logic p_reset,
    input  logic bt_in,
    output logic press
);

    if (SYNC_STAGES < 2 || DB_CYCLES < 1) begin : g_bad_params
        $error("qrd_btn_cond: SYNC_STAGES must be >= 2 and DB_CYCLES >= 1");
    end

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   level;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], bt_in};

`ifdef QRD_DEBOUNCE_EN
    localparam int unsigned CNT_W = $clog2(DB_CYCLES + 1);

    logic             db_q, db_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The level flips only after DB_CYCLES consecutive samples that disagree with it.
    always_comb begin
        db_d  = db_q;
        cnt_d = cnt_q;
        if (sync_q[SYNC_STAGES-1] == db_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
            db_d  = sync_q[SYNC_STAGES-1];
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) begin
            db_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            db_q  <= db_d;
            cnt_q <= cnt_d;
        end
    end

    assign level = db_q;
`else
    assign level = sync_q[SYNC_STAGES-1];
`endif

    assign prev_d = level;
    assign press  = level & ~prev_q;

    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

endmodule

// File: rtl/quiz_rank_detector.sv
// N-channel quiz-button arbiter: ranks rising-edge presses per round with competition ties,
// flags presses before arming as fouls. Optional debounce via QRD_DEBOUNCE_EN.
module quiz_rank_detector
    import qrd_pkg::*;
#(
    parameter int unsigned N_BTN       = QRD_N_BTN,
    parameter int unsigned RANK_W      = QRD_RANK_W,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DB_CYCLES   = 16
) (
    input  logic                     m_clock,
    input  logic                     p_reset,
    input  logic                     clear,
    input  logic                     arm,
    input  logic [N_BTN-1:0]         BT,
    output logic [N_BTN*RANK_W-1:0]  RANK_OUT,
    output logic [N_BTN-1:0]         foul,
    output logic [RANK_W-1:0]        first_id,
    output logic                     first_valid,
    output logic [RANK_W-1:0]        press_cnt,
    output logic                     all_done
);

    if (N_BTN < 2 || N_BTN > QRD_MAX_BTN || RANK_W < $clog2(N_BTN + 1)) begin : g_bad_params
        $error("quiz_rank_detector: N_BTN must be 2..16 and RANK_W must hold N_BTN");
    end

    logic [N_BTN-1:0] press;

    genvar gi;
    generate
        for (gi = 0; gi < N_BTN; gi++) begin : g_btn
            qrd_btn_cond #(
                .SYNC_STAGES (SYNC_STAGES),
                .DB_CYCLES   (DB_CYCLES)
            ) u_cond (
                .m_clock (m_clock),
                .p_reset (p_reset),
                .bt_in   (BT[gi]),
                .press   (press[gi])
            );
        end
    endgenerate

    qrd_state_e                     state_q, state_d;
    logic [N_BTN-1:0][RANK_W-1:0]   rank_q, rank_d;
    logic [N_BTN-1:0]               foul_q, foul_d;
    logic [RANK_W-1:0]              cnt_q, cnt_d;
    logic [RANK_W-1:0]              first_id_q, first_id_d;
    logic                           first_valid_q, first_valid_d;

    logic [N_BTN-1:0]       ranked;
    logic [N_BTN-1:0]       win;
    logic [QRD_MAX_BTN-1:0] win_ext;
    logic [RANK_W-1:0]      win_cnt;

    always_comb begin
        for (int i = 0; i < N_BTN; i++) begin
            ranked[i] = |rank_q[i];
        end
    end

    // Eligible presses this cycle: not yet ranked and not fouled.
    assign win = press & ~foul_q & ~ranked;

    always_comb begin
        win_ext = '0;
        win_ext[N_BTN-1:0] = win;
    end

    assign win_cnt = RANK_W'(qrd_popcount(win_ext));

    always_comb begin
        state_d       = state_q;
        rank_d        = rank_q;
        foul_d        = foul_q;
        cnt_d         = cnt_q;
        first_id_d    = first_id_q;
        first_valid_d = first_valid_q;
        if (clear) begin
            state_d       = QRD_IDLE;
            rank_d        = '0;
            foul_d        = '0;
            cnt_d         = '0;
            first_id_d    = '0;
            first_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                QRD_IDLE: begin
                    foul_d = foul_q | press;
                    if (arm) begin
                        state_d = QRD_ARMED;
                    end
                end
                QRD_ARMED: begin
                    if ((ranked | foul_q) == '1) begin
                        state_d = QRD_DONE;
                    end else begin
                        for (int i = 0; i < N_BTN; i++) begin
                            if (win[i]) begin
                                rank_d[i] = cnt_q + RANK_W'(1);
                            end
                        end
                        cnt_d = cnt_q + win_cnt;
                        // Lowest index among the rank-1 set wins the tie.
                        if (cnt_q == '0 && win != '0) begin
                            first_valid_d = 1'b1;
                            for (int i = N_BTN - 1; i >= 0; i--) begin
                                if (win[i]) begin
                                    first_id_d = RANK_W'(i);
                                end
                            end
                        end
                    end
                end
                QRD_DONE: begin
                end
                default: state_d = QRD_IDLE;
            endcase
        end
    end

    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) begin
            state_q       <= QRD_IDLE;
            rank_q        <= '0;
            foul_q        <= '0;
            cnt_q         <= '0;
            first_id_q    <= '0;
            first_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rank_q        <= rank_d;
            foul_q        <= foul_d;
            cnt_q         <= cnt_d;
            first_id_q    <= first_id_d;
            first_valid_q <= first_valid_d;
        end
    end

    assign RANK_OUT    = rank_q;
    assign foul        = foul_q;
    assign first_id    = first_id_q;
    assign first_valid = first_valid_q;
    assign press_cnt   = cnt_q;
    assign all_done    = (state_q == QRD_DONE);

endmodule

// File: tb/tb_quiz_rank_detector.sv
// Directed self-checking bench for quiz_rank_detector (default N_BTN=8, RANK_W=4, SYNC_STAGES=2).
module tb_quiz_rank_detector;

    localparam int N_BTN  = 8;
    localparam int RANK_W = 4;
`ifdef QRD_DEBOUNCE_EN
    localparam int LAT = 2 + 16 + 1;
`else
    localparam int LAT = 2 + 1;
`endif

    logic                    m_clock;
    logic                    p_reset;
    logic                    clear;
    logic                    arm;
    logic [N_BTN-1:0]        BT;
    logic [N_BTN*RANK_W-1:0] RANK_OUT;
    logic [N_BTN-1:0]        foul;
    logic [RANK_W-1:0]       first_id;
    logic                    first_valid;
    logic [RANK_W-1:0]       press_cnt;
    logic                    all_done;

    int vectors;
    int miscompares;

    quiz_rank_detector #(
        .N_BTN       (N_BTN),
        .RANK_W      (RANK_W),
        .SYNC_STAGES (2),
        .DB_CYCLES   (16)
    ) dut (
        .m_clock     (m_clock),
        .p_reset     (p_reset),
        .clear       (clear),
        .arm         (arm),
        .BT          (BT),
        .RANK_OUT    (RANK_OUT),
        .foul        (foul),
        .first_id    (first_id),
        .first_valid (first_valid),
        .press_cnt   (press_cnt),
        .all_done    (all_done)
    );

    initial m_clock = 1'b0;
    always #5 m_clock = ~m_clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge m_clock);
    endtask

    function automatic logic [RANK_W-1:0] rank_of(input int ch);
        return RANK_OUT[ch*RANK_W +: RANK_W];
    endfunction

    task automatic pulse_arm();
        arm = 1'b1;
        tick(1);
        arm = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
    endtask

    task automatic press_one(input int ch);
        BT[ch] = 1'b1;
        tick(LAT + 1);
        BT[ch] = 1'b0;
        tick(LAT + 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rank"},  RANK_OUT, '0);
        chk({tag, "_foul"},  foul, '0);
        chk({tag, "_fid"},   first_id, '0);
        chk({tag, "_fval"},  first_valid, 1'b0);
        chk({tag, "_cnt"},   press_cnt, '0);
        chk({tag, "_done"},  all_done, 1'b0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        p_reset     = 1'b0;
        clear       = 1'b0;
        arm         = 1'b0;
        BT          = '0;
        tick(3);
        chk_all_zero("reset");
        p_reset = 1'b1;
        tick(2);

        // 1: single press, latency and first winner
        pulse_arm();
        BT[3] = 1'b1;
        tick(LAT - 1);
        chk("t1_rank3_early", rank_of(3), 4'd0);
        tick(1);
        chk("t1_rank3", rank_of(3), 4'd1);
        chk("t1_first_id", first_id, 4'd3);
        chk("t1_first_valid", first_valid, 1'b1);
        chk("t1_cnt", press_cnt, 4'd1);
        BT = '0;
        tick(LAT + 1);

        // 2: tie for first then a third place
        pulse_clear();
        chk_all_zero("clr1");
        pulse_arm();
        BT[1] = 1'b1;
        BT[5] = 1'b1;
        tick(LAT + 1);
        BT[0] = 1'b1;
        tick(LAT + 1);
        chk("t2_rank1", rank_of(1), 4'd1);
        chk("t2_rank5", rank_of(5), 4'd1);
        chk("t2_rank0", rank_of(0), 4'd3);
        chk("t2_first_id", first_id, 4'd1);
        chk("t2_cnt", press_cnt, 4'd3);
        BT = '0;
        tick(LAT + 1);

        // 3: foul in IDLE, never ranked, round completes on the other seven
        pulse_clear();
        BT[2] = 1'b1;
        tick(LAT + 1);
        chk("t3_foul", foul, 8'h04);
        chk("t3_rank2_idle", rank_of(2), 4'd0);
        BT[2] = 1'b0;
        tick(LAT + 1);
        pulse_arm();
        press_one(2);
        chk("t3_rank2_armed", rank_of(2), 4'd0);
        chk("t3_cnt_after_foul", press_cnt, 4'd0);
        for (int c = 0; c < N_BTN; c++) begin
            if (c != 2) press_one(c);
            if (c == 6) chk("t3_not_done_yet", all_done, 1'b0);
        end
        begin
            int budget;
            budget = 20;
            while (!all_done && budget > 0) begin
                tick(1);
                budget--;
            end
        end
        chk("t3_all_done", all_done, 1'b1);
        chk("t3_cnt", press_cnt, 4'd7);
        chk("t3_rank7", rank_of(7), 4'd7);
        chk("t3_rank3", rank_of(3), 4'd3);
        chk("t3_rank2_final", rank_of(2), 4'd0);
        chk("t3_first_id", first_id, 4'd0);
        press_one(2);
        chk("t3_done_frozen", press_cnt, 4'd7);

        // 4: held then repeatedly pulsed button ranks once
        pulse_clear();
        pulse_arm();
        BT[4] = 1'b1;
        tick(LAT + 1);
        chk("t4_rank4", rank_of(4), 4'd1);
        for (int k = 0; k < 5; k++) begin
            BT[4] = 1'b0;
            tick(LAT + 1);
            BT[4] = 1'b1;
            tick(LAT + 1);
        end
        chk("t4_rank4_once", rank_of(4), 4'd1);
        chk("t4_cnt", press_cnt, 4'd1);
        BT = '0;
        press_one(6);
        chk("t4_rank6", rank_of(6), 4'd2);
        chk("t4_cnt2", press_cnt, 4'd2);

        // 5: clear beats arm mid-round; then asynchronous reset mid-round
        clear = 1'b1;
        arm   = 1'b1;
        tick(1);
        clear = 1'b0;
        arm   = 1'b0;
        chk_all_zero("t5_clr_arm");
        BT[0] = 1'b1;
        tick(LAT + 1);
        chk("t5_idle_foul", foul, 8'h01);
        chk("t5_idle_norank", RANK_OUT, '0);
        BT = '0;
        tick(LAT + 1);
        pulse_clear();
        pulse_arm();
        BT[1] = 1'b1;
        tick(LAT + 1);
        chk("t5_pre_reset_rank1", rank_of(1), 4'd1);
        BT = '0;
        #2 p_reset = 1'b0;
        #1 chk_all_zero("t5_async_rst");
        tick(1);
        p_reset = 1'b1;
        tick(1);
        chk_all_zero("t5_post_rst");

`ifdef QRD_DEBOUNCE_EN
        // 6: glitch rejected, stable press accepted at full latency
        pulse_arm();
        BT[0] = 1'b1;
        tick(10);
        BT[0] = 1'b0;
        tick(40);
        chk("t6_glitch", RANK_OUT, '0);
        BT[0] = 1'b1;
        tick(LAT - 1);
        chk("t6_rank0_early", rank_of(0), 4'd0);
        tick(1);
        chk("t6_rank0", rank_of(0), 4'd1);
        BT = '0;
        tick(2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
